// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous motion and animation controller for one sprite.
// Position, heading and animation frame change only on the vsync falling edge.
module sprite_motion_ctrl #(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 383,
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_i,
  input  logic       enable,
  input  logic [2:0] speed,
  input  logic       dir_mode,
  output logic [9:0] pos_x,
  output logic       dir,
  output logic       anim_idx,
  output logic       frame_upd
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(ANIM_DIV - 1);

  typedef enum logic [1:0] {IDLE, RIGHT, LEFT} state_e;

  state_e             state_q;
  logic [9:0]         pos_q;
  logic               dir_q;
  logic               anim_q;
  logic               upd_q;
  logic               vsync_q;
  logic [CW-1:0]      cnt_q;

  logic               tick;
  logic signed [10:0] nxt;
  logic [9:0]         pos_d;
  logic               dir_d;

  assign tick = vsync_q & ~vsync_i;

  always_comb begin
    if (dir_q) nxt = $signed({1'b0, pos_q}) - $signed({8'd0, speed});
    else       nxt = $signed({1'b0, pos_q}) + $signed({8'd0, speed});
    pos_d = 10'(nxt);
    dir_d = dir_q;
    // Exact landing on an edge is in range, so it neither wraps nor flips.
    if (nxt > XMAX_S) begin
      if (dir_mode) begin
        pos_d = 10'(XMAX_S - (nxt - XMAX_S));
        dir_d = 1'b1;
      end else begin
        pos_d = 10'(XMIN_S + (nxt - XMAX_S - 11'sd1));
      end
    end else if (nxt < XMIN_S) begin
      if (dir_mode) begin
        pos_d = 10'(XMIN_S + (XMIN_S - nxt));
        dir_d = 1'b0;
      end else begin
        pos_d = 10'(XMAX_S - (XMIN_S - nxt - 11'sd1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= 10'(X_MIN);
      dir_q   <= 1'b0;
      anim_q  <= 1'b0;
      upd_q   <= 1'b0;
      vsync_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      vsync_q <= vsync_i;
      upd_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) state_q <= dir_q ? LEFT : RIGHT;
        end
        RIGHT, LEFT: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (tick) begin
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            state_q <= dir_d ? LEFT : RIGHT;
            upd_q   <= 1'b1;
            if (speed != 3'd0) begin
              if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                anim_q <= ~anim_q;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pos_x     = pos_q;
  assign dir       = dir_q;
  assign anim_idx  = anim_q;
  assign frame_upd = upd_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed scenarios plus a randomized run,
// every cycle compared against a frame-level reference model.
module tb_sprite_motion_ctrl;

  localparam int XMIN = 0;
  localparam int XMAX = 20;
  localparam int ADIV = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync_i;
  logic       enable;
  logic [2:0] speed;
  logic       dir_mode;
  logic [9:0] pos_x;
  logic       dir;
  logic       anim_idx;
  logic       frame_upd;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // reference model state
  int m_pos;
  int m_upd_cnt;
  bit m_dir, m_anim, m_fu, m_active, m_vs;

  sprite_motion_ctrl #(.X_MIN(XMIN), .X_MAX(XMAX), .ANIM_DIV(ADIV)) dut (
    .clk(clk), .reset(reset), .vsync_i(vsync_i), .enable(enable),
    .speed(speed), .dir_mode(dir_mode), .pos_x(pos_x), .dir(dir),
    .anim_idx(anim_idx), .frame_upd(frame_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = XMIN; m_dir = 0; m_anim = 0; m_fu = 0;
    m_active = 0; m_vs = 1; m_upd_cnt = 0;
  endtask

  // A tick counts only when motion was already active before this edge and
  // enable is still high at it.
  task automatic model_edge();
    int s, nxt;
    bit tick;
    tick = m_vs && !vsync_i;
    m_fu = 0;
    if (tick && m_active && enable) begin
      s = int'(speed);
      nxt = m_dir ? m_pos - s : m_pos + s;
      if (!dir_mode) begin
        if (nxt > XMAX) nxt = nxt - (XMAX - XMIN + 1);
        else if (nxt < XMIN) nxt = nxt + (XMAX - XMIN + 1);
      end else begin
        if (nxt > XMAX) begin nxt = 2 * XMAX - nxt; m_dir = 1; end
        else if (nxt < XMIN) begin nxt = 2 * XMIN - nxt; m_dir = 0; end
      end
      m_pos = nxt;
      if (s != 0) begin
        m_upd_cnt++;
        if (m_upd_cnt % ADIV == 0) m_anim = ~m_anim;
      end
      m_fu = 1;
    end
    m_active = enable;
    m_vs = vsync_i;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (frame_upd === 1'b1) pulses++;
    chk("pos_x", pos_x, m_pos);
    chk("dir", dir, m_dir);
    chk("anim_idx", anim_idx, m_anim);
    chk("frame_upd", frame_upd, m_fu);
  endtask

  task automatic frame(input int hi = 3, input int lo = 3);
    vsync_i = 1'b1;
    repeat (hi) cyc();
    vsync_i = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_pos", pos_x, XMIN);
    chk("rst_dir", dir, 0);
    chk("rst_anim", anim_idx, 0);
    chk("rst_upd", frame_upd, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int wexp[4];
    int bexp[6];
    int dexp[6];
    wexp = '{7, 14, 0, 7};
    bexp = '{7, 14, 19, 12, 5, 2};
    dexp = '{0, 0, 1, 1, 1, 0};

    reset = 1'b1; vsync_i = 1'b1; enable = 1'b0; speed = 3'd0; dir_mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc();

    // linear move
    enable = 1'b1; speed = 3'd3;
    cyc();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("lin_pos", pos_x, 3 * (i + 1));
    end
    chk("lin_pulses", pulses, 4);

    // reset mid-frame, released with vsync held low
    vsync_i = 1'b1;
    cyc();
    chk("pre_rst_pos", pos_x, 12);
    vsync_i = 1'b0;
    do_reset();
    pulses = 0;
    repeat (4) cyc();
    chk("rst_no_upd", pulses, 0);

    // wrap to the right
    speed = 3'd7; dir_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("wrap_pos", pos_x, wexp[i]);
      chk("wrap_dir", dir, 0);
    end

    // bounce sequence
    do_reset();
    cyc();
    speed = 3'd7; dir_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame();
      chk("bnc_pos", pos_x, bexp[i]);
      chk("bnc_dir", dir, dexp[i]);
    end

    // exact landing on X_MAX, then reflect, then wrap to the left
    do_reset();
    cyc();
    speed = 3'd5; dir_mode = 1'b1;
    repeat (4) frame();
    chk("land_pos", pos_x, 20);
    chk("land_dir", dir, 0);
    speed = 3'd7;
    frame();
    chk("refl_pos", pos_x, 13);
    chk("refl_dir", dir, 1);
    speed = 3'd5;
    repeat (2) frame();
    chk("left_pos", pos_x, 3);
    speed = 3'd7; dir_mode = 1'b0;
    frame();
    chk("wrapl_pos", pos_x, 17);
    chk("wrapl_dir", dir, 1);

    // animation cadence
    do_reset();
    cyc();
    speed = 3'd1; dir_mode = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      frame();
      chk("anim_seq", anim_idx, (i >= 8 && i < 16) ? 1 : 0);
    end
    chk("anim_pos", pos_x, 16);
    speed = 3'd0;
    pulses = 0;
    repeat (10) frame();
    chk("frz_pulses", pulses, 10);
    chk("frz_pos", pos_x, 16);
    chk("frz_anim", anim_idx, 0);

    // enable gating
    do_reset();
    cyc();
    speed = 3'd3;
    repeat (2) frame();
    chk("gate_pos0", pos_x, 6);
    enable = 1'b0;
    pulses = 0;
    repeat (3) frame();
    chk("gate_pos1", pos_x, 6);
    chk("gate_pulses", pulses, 0);
    enable = 1'b1;
    cyc();
    frame();
    chk("gate_pos2", pos_x, 9);
    vsync_i = 1'b1;
    repeat (2) cyc();
    vsync_i = 1'b0; enable = 1'b0;
    cyc();
    chk("coinc_upd", frame_upd, 0);
    chk("coinc_pos", pos_x, 9);

    // randomized run
    enable = 1'b1;
    cyc();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) speed = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) dir_mode = ~dir_mode;
      if ($urandom_range(0, 3) == 0) vsync_i = ~vsync_i;
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
